// File: rtl/wm_bit_extract.sv
// wm_bit_extract: recovers watermark bits from a two-pixel-per-clock RGB
// stream. Bit BIT_POS of each blue channel is packed MSB-first into bytes,
// buffered in a FIFO and offered on a valid/ready byte port.
// Optional feature macro: WM_CHECKSUM_EN appends an XOR checksum byte after
// the flush.
//
// Handshake: a byte transfers on a rising HCLK edge where BYTE_VALID and
// BYTE_READY are both high; BYTE_DATA is held while BYTE_VALID=1 and
// BYTE_READY=0; BYTE_READY while the FIFO is empty has no effect.
module wm_bit_extract #(
    parameter int FIFO_DEPTH = 16,
    parameter int BIT_POS    = 0,
    parameter int CNT_W      = 16
) (
    input  logic             HCLK,
    input  logic             HRESETn,
    input  logic             HSYNC,
    input  logic [7:0]       DATA_R0,
    input  logic [7:0]       DATA_G0,
    input  logic [7:0]       DATA_B0,
    input  logic [7:0]       DATA_R1,
    input  logic [7:0]       DATA_G1,
    input  logic [7:0]       DATA_B1,
    input  logic             CTRL_DONE,
    output logic [7:0]       BYTE_DATA,
    output logic             BYTE_VALID,
    input  logic             BYTE_READY,
    output logic [CNT_W-1:0] BYTE_COUNT,
    output logic             OVERFLOW,
    output logic             FRAME_DONE,
    output logic [2:0]       DBG_STATE
);

    localparam int AW = $clog2(FIFO_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_COLLECT = 3'd1,
        S_FLUSH   = 3'd2,
`ifdef WM_CHECKSUM_EN
        S_CKSUM   = 3'd3,
`endif
        S_DONE    = 3'd4
    } state_t;

    state_t           state_q, state_d;
    logic [7:0]       sr_q, sr_d;
    logic [2:0]       cnt_q, cnt_d;
    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic [7:0]       mem_q [FIFO_DEPTH];
    logic [7:0]       mem_d [FIFO_DEPTH];
    logic [CNT_W-1:0] byte_count_q, byte_count_d;
    logic             overflow_q, overflow_d;
    logic             frame_done_q, frame_done_d;
`ifdef WM_CHECKSUM_EN
    logic [7:0]       cksum_q, cksum_d;
`endif

    logic       bit0, bit1;
    logic       wr_req;
    logic [7:0] wr_data;
    logic [3:0] pad_shamt;
    logic       fifo_empty, fifo_full, pop, push;
    logic       unused_inputs;

    // Red/green and the other blue bits only travel with the stream.
    assign unused_inputs = ^{DATA_R0, DATA_G0, DATA_R1, DATA_G1, DATA_B0, DATA_B1};

    assign bit0      = DATA_B0[BIT_POS];
    assign bit1      = DATA_B1[BIT_POS];
    assign pad_shamt = 4'd8 - {1'b0, cnt_q};

    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                        (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign pop        = !fifo_empty && BYTE_READY;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign push       = wr_req && (!fifo_full || pop);

    // Frame FSM: bit collection, flush of the partial byte, optional checksum.
    always_comb begin
        state_d = state_q;
        sr_d    = sr_q;
        cnt_d   = cnt_q;
        wr_req  = 1'b0;
        wr_data = 8'h00;
        case (state_q)
            S_IDLE, S_COLLECT: begin
                if (HSYNC) begin
                    if (cnt_q == 3'd6) begin
                        wr_req  = 1'b1;
                        wr_data = {sr_q[5:0], bit0, bit1};
                        sr_d    = 8'h00;
                        cnt_d   = 3'd0;
                    end else begin
                        sr_d  = {sr_q[5:0], bit0, bit1};
                        cnt_d = cnt_q + 3'd2;
                    end
                    state_d = S_COLLECT;
                end
                // Same-cycle bits are captured above before moving to flush.
                if (CTRL_DONE) begin
                    state_d = S_FLUSH;
                end
            end
            S_FLUSH: begin
                if (cnt_q != 3'd0) begin
                    wr_req  = 1'b1;
                    wr_data = sr_q << pad_shamt;
                end
                sr_d  = 8'h00;
                cnt_d = 3'd0;
`ifdef WM_CHECKSUM_EN
                state_d = S_CKSUM;
`else
                state_d = S_DONE;
`endif
            end
`ifdef WM_CHECKSUM_EN
            S_CKSUM: begin
                wr_req  = 1'b1;
                wr_data = cksum_q;
                state_d = S_DONE;
            end
`endif
            S_DONE: begin
                state_d = S_DONE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // FIFO pointers, storage, byte counter and status flags.
    always_comb begin
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        mem_d        = mem_q;
        byte_count_d = byte_count_q;
        overflow_d   = overflow_q;
        frame_done_d = frame_done_q;
        if (push) begin
            mem_d[wr_ptr_q[AW-1:0]] = wr_data;
            wr_ptr_d                = wr_ptr_q + 1'b1;
            byte_count_d            = byte_count_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        if (wr_req && fifo_full && !pop) begin
            overflow_d = 1'b1;
        end
        if (state_q == S_DONE && fifo_empty) begin
            frame_done_d = 1'b1;
        end
    end

`ifdef WM_CHECKSUM_EN
    // Running XOR over every byte that actually entered the FIFO.
    always_comb begin
        cksum_d = cksum_q;
        if (push) begin
            cksum_d = cksum_q ^ wr_data;
        end
    end
`endif

    // State registers, cleared asynchronously.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q      <= S_IDLE;
            sr_q         <= 8'h00;
            cnt_q        <= 3'd0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            byte_count_q <= '0;
            overflow_q   <= 1'b0;
            frame_done_q <= 1'b0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= 8'h00;
            end
`ifdef WM_CHECKSUM_EN
            cksum_q      <= 8'h00;
`endif
        end else begin
            state_q      <= state_d;
            sr_q         <= sr_d;
            cnt_q        <= cnt_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            byte_count_q <= byte_count_d;
            overflow_q   <= overflow_d;
            frame_done_q <= frame_done_d;
            mem_q        <= mem_d;
`ifdef WM_CHECKSUM_EN
            cksum_q      <= cksum_d;
`endif
        end
    end

    assign BYTE_VALID = !fifo_empty;
    assign BYTE_DATA  = fifo_empty ? 8'h00 : mem_q[rd_ptr_q[AW-1:0]];
    assign BYTE_COUNT = byte_count_q;
    assign OVERFLOW   = overflow_q;
    assign FRAME_DONE = frame_done_q;
    assign DBG_STATE  = state_q;

endmodule

// File: tb/tb_wm_bit_extract.sv
// tb_wm_bit_extract: directed and randomized frames for wm_bit_extract,
// checked against a bit-list reference model of the extraction rules.
module tb_wm_bit_extract;

  localparam int DEPTH = 16;
  localparam int BPOS  = 0;
  localparam int CW    = 16;

  logic          HCLK = 1'b0;
  logic          HRESETn = 1'b0;
  logic          HSYNC = 1'b0;
  logic [7:0]    DATA_R0 = '0, DATA_G0 = '0, DATA_B0 = '0;
  logic [7:0]    DATA_R1 = '0, DATA_G1 = '0, DATA_B1 = '0;
  logic          CTRL_DONE = 1'b0;
  logic [7:0]    BYTE_DATA;
  logic          BYTE_VALID;
  logic          BYTE_READY = 1'b0;
  logic [CW-1:0] BYTE_COUNT;
  logic          OVERFLOW;
  logic          FRAME_DONE;
  logic [2:0]    DBG_STATE;

  int checks = 0;
  int failures = 0;

  // model state
  bit         bits_q[$];
  logic [7:0] exp_q[$];
  int         m_count;
  bit         m_ovf;
  logic [7:0] m_xor;
  bit         m_flushed;

  wm_bit_extract #(.FIFO_DEPTH(DEPTH), .BIT_POS(BPOS), .CNT_W(CW)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .HSYNC(HSYNC),
    .DATA_R0(DATA_R0), .DATA_G0(DATA_G0), .DATA_B0(DATA_B0),
    .DATA_R1(DATA_R1), .DATA_G1(DATA_G1), .DATA_B1(DATA_B1),
    .CTRL_DONE(CTRL_DONE), .BYTE_DATA(BYTE_DATA), .BYTE_VALID(BYTE_VALID),
    .BYTE_READY(BYTE_READY), .BYTE_COUNT(BYTE_COUNT), .OVERFLOW(OVERFLOW),
    .FRAME_DONE(FRAME_DONE), .DBG_STATE(DBG_STATE)
  );

  // clock
  always #5 HCLK = ~HCLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // model: write attempt into a FIFO that nobody drains while producing
  task automatic m_write(input logic [7:0] b);
    if (exp_q.size() < DEPTH) begin
      exp_q.push_back(b);
      m_count++;
      m_xor = m_xor ^ b;
    end else begin
      m_ovf = 1'b1;
    end
  endtask

  task automatic m_emit_bits();
    logic [7:0] b;
    b = 8'h00;
    for (int i = 0; i < bits_q.size(); i++) b[7-i] = bits_q[i];
    bits_q.delete();
    m_write(b);
  endtask

  task automatic m_flush();
    if (bits_q.size() > 0) m_emit_bits();
`ifdef WM_CHECKSUM_EN
    m_write(m_xor);
`endif
    m_flushed = 1'b1;
  endtask

  task automatic m_clear();
    bits_q.delete();
    exp_q.delete();
    m_count = 0;
    m_ovf = 1'b0;
    m_xor = 8'h00;
    m_flushed = 1'b0;
  endtask

  // driver: one clock cycle of stream input, model updated alongside
  task automatic drive_cycle(input bit hs, input bit b0, input bit b1, input bit cd);
    logic [7:0] v0, v1;
    v0 = 8'($urandom);
    v1 = 8'($urandom);
    v0[BPOS] = b0;
    v1[BPOS] = b1;
    HSYNC = hs;
    CTRL_DONE = cd;
    DATA_B0 = v0;
    DATA_B1 = v1;
    DATA_R0 = 8'($urandom); DATA_G0 = 8'($urandom);
    DATA_R1 = 8'($urandom); DATA_G1 = 8'($urandom);
    if (!m_flushed) begin
      if (hs) begin
        bits_q.push_back(b0);
        bits_q.push_back(b1);
        if (bits_q.size() == 8) m_emit_bits();
      end
      if (cd) m_flush();
    end
    @(posedge HCLK);
    #1;
    HSYNC = 1'b0;
    CTRL_DONE = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive_cycle(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    HRESETn = 1'b0;
    BYTE_READY = 1'b0;
    HSYNC = 1'b0;
    CTRL_DONE = 1'b0;
    m_clear();
    repeat (2) @(posedge HCLK);
    #3;
    HRESETn = 1'b1;
    @(posedge HCLK);
    #1;
  endtask

  // scoreboard drain: every popped byte must match the expected queue head
  task automatic drain(input string tag);
    int n;
    n = 0;
    BYTE_READY = 1'b1;
    while ((exp_q.size() > 0 || BYTE_VALID) && n < 200) begin
      if (BYTE_VALID) begin
        if (exp_q.size() > 0) check({tag, "_data"}, BYTE_DATA, exp_q.pop_front());
        else check({tag, "_extra_byte"}, {31'd0, BYTE_VALID}, 32'd0);
      end
      @(posedge HCLK);
      #1;
      n++;
    end
    BYTE_READY = 1'b0;
    check({tag, "_timeout"}, n < 200, 1);
    check({tag, "_left"}, exp_q.size(), 0);
  endtask

  task automatic wait_frame_done(input string tag);
    int n;
    n = 0;
    while (!FRAME_DONE && n < 20) begin
      idle(1);
      n++;
    end
    check(tag, {31'd0, FRAME_DONE}, 32'd1);
  endtask

  initial begin
    logic [1:0] pat2 [8];
    int npairs;

    // T0: reset values
    do_reset();
    check("rst_valid", {31'd0, BYTE_VALID}, 0);
    check("rst_data", BYTE_DATA, 0);
    check("rst_count", BYTE_COUNT, 0);
    check("rst_ovf", {31'd0, OVERFLOW}, 0);
    check("rst_fdone", {31'd0, FRAME_DONE}, 0);
    check("rst_state", DBG_STATE, 0);

    // T1: 0xAA, one-cycle latency
    for (int i = 0; i < 3; i++) drive_cycle(1'b1, 1'b1, 1'b0, 1'b0);
    check("aa_valid_early", {31'd0, BYTE_VALID}, 0);
    drive_cycle(1'b1, 1'b1, 1'b0, 1'b0);
    check("aa_valid", {31'd0, BYTE_VALID}, 1);
    check("aa_data", BYTE_DATA, 8'hAA);
    check("aa_count", BYTE_COUNT, m_count);
    drive_cycle(1'b0, 1'b0, 1'b0, 1'b1);
    idle(2);
    drain("aa");
    wait_frame_done("aa_fdone");

    // T2: 0xC3, 0x0F with HSYNC gaps; data held while not ready
    do_reset();
    pat2 = '{2'b11, 2'b00, 2'b00, 2'b11, 2'b00, 2'b00, 2'b11, 2'b11};
    for (int i = 0; i < 8; i++) begin
      drive_cycle(1'b1, pat2[i][1], pat2[i][0], 1'b0);
      idle(1);
    end
    check("c3_head", BYTE_DATA, 8'hC3);
    for (int i = 0; i < 5; i++) begin
      idle(1);
      check("c3_hold", BYTE_DATA, 8'hC3);
    end
    drive_cycle(1'b0, 1'b0, 1'b0, 1'b1);
    idle(2);
    check("c3_count", BYTE_COUNT, m_count);
`ifdef WM_CHECKSUM_EN
    check("c3_cksum_count", BYTE_COUNT, 3);
`endif
    drain("c3");
    wait_frame_done("c3_fdone");

    // T3: partial byte 0xFC padded on flush
    do_reset();
    for (int i = 0; i < 3; i++) drive_cycle(1'b1, 1'b1, 1'b1, 1'b0);
    drive_cycle(1'b0, 1'b0, 1'b0, 1'b1);
    idle(3);
    check("fc_fdone_early", {31'd0, FRAME_DONE}, 0);
    check("fc_head", BYTE_DATA, 8'hFC);
    check("fc_count", BYTE_COUNT, m_count);
    drain("fc");
    wait_frame_done("fc_fdone");

    // T4: overflow at DEPTH
    do_reset();
    for (int i = 0; i < DEPTH * 4; i++)
      drive_cycle(1'b1, 1'($urandom), 1'($urandom), 1'b0);
    check("ovf_before", {31'd0, OVERFLOW}, 0);
    check("ovf_full_count", BYTE_COUNT, DEPTH);
    for (int i = 0; i < 4; i++)
      drive_cycle(1'b1, 1'($urandom), 1'($urandom), 1'b0);
    check("ovf_set", {31'd0, OVERFLOW}, {31'd0, m_ovf});
    check("ovf_count", BYTE_COUNT, m_count);
    drain("ovf");
    check("ovf_sticky", {31'd0, OVERFLOW}, 1);

    // T5: reset mid-frame
    do_reset();
    for (int i = 0; i < 6; i++)
      drive_cycle(1'b1, 1'($urandom), 1'($urandom), 1'b0);
    HRESETn = 1'b0;
    #1;
    check("mrst_valid", {31'd0, BYTE_VALID}, 0);
    check("mrst_count", BYTE_COUNT, 0);
    #2;
    HRESETn = 1'b1;
    m_clear();
    @(posedge HCLK);
    #1;
    for (int i = 0; i < 4; i++) drive_cycle(1'b1, 1'b1, 1'b1, 1'b0);
    check("mrst_ff", BYTE_DATA, 8'hFF);
    check("mrst_ff_count", BYTE_COUNT, m_count);
    drain("mrst");

    // T6: HSYNC and CTRL_DONE together at count 6
    do_reset();
    for (int i = 0; i < 3; i++)
      drive_cycle(1'b1, 1'($urandom), 1'($urandom), 1'b0);
    drive_cycle(1'b1, 1'($urandom), 1'($urandom), 1'b1);
    idle(3);
    check("sim_count", BYTE_COUNT, m_count);
    drain("sim");
    wait_frame_done("sim_fdone");

    // T7: CTRL_DONE with no data seen
    do_reset();
    drive_cycle(1'b0, 1'b0, 1'b0, 1'b1);
    idle(3);
    check("empty_count", BYTE_COUNT, m_count);
    drain("empty");
    wait_frame_done("empty_fdone");

    // T8: randomized frames
    for (int f = 0; f < 6; f++) begin
      do_reset();
      npairs = $urandom_range(0, 30);
      for (int i = 0; i < npairs; i++) begin
        drive_cycle(1'b1, 1'($urandom), 1'($urandom), 1'b0);
        if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
      end
      drive_cycle(1'($urandom), 1'($urandom), 1'($urandom), 1'b1);
      drive_cycle(1'b1, 1'($urandom), 1'($urandom), 1'b1);
      idle(3);
      check("rnd_count", BYTE_COUNT, m_count);
      check("rnd_ovf", {31'd0, OVERFLOW}, {31'd0, m_ovf});
      drain("rnd");
      wait_frame_done("rnd_fdone");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
